// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding and load-use hazard detection
//
// Tracks the destination of the last NSTAGE issued instructions in a
// shift register and, per source channel, selects either register-file
// data or the youngest in-flight result that targets the same register.
// A load whose data is not yet available (stage index < LD_STAGE) and
// that wins the forwarding search holds issue for one cycle.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   issue_*        instruction presented for issue (valid/we/is_load/rd/rs)
//   rf_data        register-file read data, one SIZE word per channel
//   stage_data     result held by each in-flight stage, one SIZE word per stage
//   flush          invalidate every in-flight entry at the next edge
//   src_o          forwarded operand per channel
//   fwd_sel_o      per channel: 0 = register file, k+1 = stage k
//   stall_o        load-use hazard, issue must be held this cycle
//   stall_cnt_o    saturating count of stall cycles
module fwd_hazard_unit #(
    parameter int SIZE     = 32,
    parameter int NSRC     = 2,
    parameter int NSTAGE   = 3,
    parameter int AW       = 5,
    parameter int LD_STAGE = 1,
    parameter int CW       = 16,
    localparam int SW      = $clog2(NSTAGE + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    input  logic                   issue_we,
    input  logic                   issue_is_load,
    input  logic [AW-1:0]          issue_rd,
    input  logic [NSRC*AW-1:0]     issue_rs,
    input  logic [NSRC*SIZE-1:0]   rf_data,
    input  logic [NSTAGE*SIZE-1:0] stage_data,
    input  logic                   flush,
    output logic [NSRC*SIZE-1:0]   src_o,
    output logic [NSRC*SW-1:0]     fwd_sel_o,
    output logic                   stall_o,
    output logic [CW-1:0]          stall_cnt_o
);

    logic [NSTAGE-1:0] valid_q, valid_d;
    logic [NSTAGE-1:0] we_q, we_d;
    logic [NSTAGE-1:0] ld_q, ld_d;
    logic [AW-1:0]     rd_q [NSTAGE];
    logic [AW-1:0]     rd_d [NSTAGE];
    logic [CW-1:0]     stall_cnt_q, stall_cnt_d;

    // Per channel: the winning (youngest) match is a load still in flight.
    logic [NSRC-1:0]   hit_ld;

    // Forwarding search. Walking from oldest to youngest lets the
    // youngest match overwrite older ones, so the lowest k wins.
    always_comb begin
        src_o     = rf_data;
        fwd_sel_o = '0;
        hit_ld    = '0;
        for (int c = 0; c < NSRC; c++) begin
            for (int k = NSTAGE - 1; k >= 0; k--) begin
                if (valid_q[k] && we_q[k] &&
                    (rd_q[k] == issue_rs[c*AW +: AW]) &&
                    (issue_rs[c*AW +: AW] != '0)) begin
                    src_o[c*SIZE +: SIZE] = stage_data[k*SIZE +: SIZE];
                    fwd_sel_o[c*SW +: SW] = SW'(k + 1);
                    hit_ld[c]             = ld_q[k] && (k < LD_STAGE);
                end
            end
        end
        stall_o = issue_valid && !flush && (|hit_ld);
    end

    // Pipeline advance: a stalled issue enters as a bubble; flush wipes
    // every entry including the one being issued this cycle.
    always_comb begin
        valid_d[0] = issue_valid && !stall_o;
        we_d[0]    = issue_we;
        ld_d[0]    = issue_is_load;
        rd_d[0]    = issue_rd;
        for (int k = 1; k < NSTAGE; k++) begin
            valid_d[k] = valid_q[k-1];
            we_d[k]    = we_q[k-1];
            ld_d[k]    = ld_q[k-1];
            rd_d[k]    = rd_q[k-1];
        end
        if (flush) begin
            valid_d = '0;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            we_q        <= '0;
            ld_q        <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                rd_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            we_q        <= we_d;
            ld_q        <= ld_d;
            for (int k = 0; k < NSTAGE; k++) begin
                rd_q[k] <= rd_d[k];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

    localparam int SIZE     = 32;
    localparam int NSRC     = 2;
    localparam int NSTAGE   = 3;
    localparam int AW       = 5;
    localparam int LD_STAGE = 1;
    localparam int CW       = 2;
    localparam int SW       = $clog2(NSTAGE + 1);
    localparam int MAXC     = (1 << CW) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   issue_valid = 1'b0;
    logic                   issue_we = 1'b0;
    logic                   issue_is_load = 1'b0;
    logic [AW-1:0]          issue_rd = '0;
    logic [NSRC*AW-1:0]     issue_rs = '0;
    logic [NSRC*SIZE-1:0]   rf_data;
    logic [NSTAGE*SIZE-1:0] stage_data;
    logic                   flush = 1'b0;
    logic [NSRC*SIZE-1:0]   src_o;
    logic [NSRC*SW-1:0]     fwd_sel_o;
    logic                   stall_o;
    logic [CW-1:0]          stall_cnt_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .SIZE(SIZE), .NSRC(NSRC), .NSTAGE(NSTAGE), .AW(AW),
        .LD_STAGE(LD_STAGE), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_is_load(issue_is_load), .issue_rd(issue_rd),
        .issue_rs(issue_rs), .rf_data(rf_data), .stage_data(stage_data),
        .flush(flush), .src_o(src_o), .fwd_sel_o(fwd_sel_o),
        .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
    );

    // Reference model: a history of issued instructions, youngest first.
    typedef struct {
        bit           v;
        bit           we;
        bit           ld;
        bit [AW-1:0]  rd;
    } ent_t;

    ent_t hist[$];
    int   mcnt;

    task automatic model_reset();
        ent_t e;
        e = '{0, 0, 0, 0};
        hist.delete();
        for (int i = 0; i < NSTAGE; i++) hist.push_back(e);
        mcnt = 0;
    endtask

    function automatic int m_sel(int c);
        bit [AW-1:0] r;
        r = issue_rs[c*AW +: AW];
        for (int i = 0; i < hist.size(); i++)
            if (hist[i].v && hist[i].we && hist[i].rd == r && r != 0)
                return i + 1;
        return 0;
    endfunction

    function automatic bit m_stall();
        int s;
        if (!issue_valid || flush) return 1'b0;
        for (int c = 0; c < NSRC; c++) begin
            s = m_sel(c);
            if (s != 0 && hist[s-1].ld && (s - 1) < LD_STAGE) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_update();
        ent_t e;
        bit   st;
        st   = m_stall();
        e.v  = issue_valid && !st;
        e.we = issue_we;
        e.ld = issue_is_load;
        e.rd = issue_rd;
        hist.push_front(e);
        void'(hist.pop_back());
        if (flush) foreach (hist[i]) hist[i].v = 1'b0;
        if (st && mcnt < MAXC) mcnt++;
    endtask

    function automatic logic [SIZE-1:0] exp_src(int c, int s);
        if (s == 0) return rf_data[c*SIZE +: SIZE];
        return stage_data[(s-1)*SIZE +: SIZE];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all(string tag, int s0, int s1, int st, int cn);
        check({tag, " fwd_sel0"}, 32'(fwd_sel_o[0 +: SW]), s0);
        check({tag, " fwd_sel1"}, 32'(fwd_sel_o[SW +: SW]), s1);
        check({tag, " src0"}, src_o[0 +: SIZE], exp_src(0, s0));
        check({tag, " src1"}, src_o[SIZE +: SIZE], exp_src(1, s1));
        check({tag, " stall"}, 32'(stall_o), st);
        check({tag, " stall_cnt"}, 32'(stall_cnt_o), cn);
    endtask

    task automatic drive(bit iv, bit we, bit ld, int rd, int rs0, int rs1, bit fl);
        issue_valid   = iv;
        issue_we      = we;
        issue_is_load = ld;
        issue_rd      = AW'(rd);
        issue_rs      = {AW'(rs1), AW'(rs0)};
        flush         = fl;
    endtask

    task automatic next_cycle();
        model_update();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit iv; bit we; bit ld; int rd; int rs0; int rs1;
        int s0; int s1; int st; int cnt;
    } vec_t;

    vec_t tbl[14];

    initial begin
        rf_data    = {32'h1111_2222, 32'h3333_4444};
        stage_data = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_5555};
        model_reset();

        //           iv we ld rd rs0 rs1  s0 s1 st cnt
        tbl[0]  = '{1, 1, 0, 5, 0, 0,  0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 7, 5, 0,  1, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 7, 0, 7,  0, 2, 0, 0};
        tbl[4]  = '{1, 1, 0, 0, 7, 7,  1, 1, 0, 0};
        tbl[5]  = '{1, 1, 1, 3, 0, 7,  0, 2, 0, 0};
        tbl[6]  = '{1, 1, 0, 9, 3, 0,  1, 0, 1, 0};
        tbl[7]  = '{1, 1, 0, 9, 3, 0,  2, 0, 0, 1};
        tbl[8]  = '{0, 0, 0, 0, 3, 9,  3, 1, 0, 1};
        tbl[9]  = '{1, 1, 1, 4, 9, 0,  2, 0, 0, 1};
        tbl[10] = '{0, 1, 1, 4, 4, 0,  1, 0, 0, 1};
        tbl[11] = '{1, 1, 1, 4, 0, 4,  0, 2, 0, 1};
        tbl[12] = '{1, 0, 0, 0, 4, 0,  1, 0, 1, 1};
        tbl[13] = '{1, 0, 0, 0, 4, 0,  2, 0, 0, 2};

        // Reset state, with inputs that would otherwise match.
        drive(1, 1, 1, 5, 5, 5, 0);
        @(negedge clk);
        compare_all("reset", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].we, tbl[i].ld, tbl[i].rd,
                  tbl[i].rs0, tbl[i].rs1, 0);
            @(negedge clk);
            compare_all($sformatf("vec%0d", i), tbl[i].s0, tbl[i].s1,
                        tbl[i].st, tbl[i].cnt);
            next_cycle();
        end

        // Three more load-use stalls: 5 in total, counter saturates at 3.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 6, 0, 0, 0);
            next_cycle();
            drive(1, 0, 0, 0, 6, 0, 0);
            @(negedge clk);
            check($sformatf("sat stall%0d", i), 32'(stall_o), 1);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("sat count", 32'(stall_cnt_o), MAXC);
        next_cycle();

        // Flush: forces stall low, kills in-flight entries and the issue.
        drive(1, 1, 1, 8, 0, 0, 0);
        next_cycle();
        drive(1, 1, 0, 10, 8, 0, 1);
        @(negedge clk);
        compare_all("flush", 1, 0, 0, MAXC);
        next_cycle();
        drive(1, 0, 0, 0, 8, 10, 0);
        @(negedge clk);
        compare_all("post_flush", 0, 0, 0, MAXC);
        next_cycle();

        // Asynchronous reset in the middle of a stall.
        drive(1, 1, 1, 11, 0, 0, 0);
        next_cycle();
        drive(1, 0, 0, 0, 11, 11, 0);
        @(negedge clk);
        compare_all("pre_rst", 1, 1, 1, MAXC);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("async_rst", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        compare_all("after_rst", 0, 0, 0, 0);
        next_cycle();

        // Randomized traffic against the model, small register space.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NSTAGE; k++) stage_data[k*SIZE +: SIZE] = $urandom;
            for (int c = 0; c < NSRC; c++) rf_data[c*SIZE +: SIZE] = $urandom;
            drive(bit'($urandom_range(1)), bit'($urandom_range(1)),
                  bit'($urandom_range(1)), $urandom_range(3),
                  $urandom_range(3), $urandom_range(3),
                  ($urandom_range(15) == 0));
            @(negedge clk);
            compare_all("rnd", m_sel(0), m_sel(1), int'(m_stall()), mcnt);
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter SIZE, default 32: operand/result data width.
REQ-002 SHALL have parameter NSRC, default 2: number of source-operand channels.
REQ-003 SHALL have parameter NSTAGE, default 3: number of tracked in-flight stages after issue (forwarding sources).
REQ-004 SHALL have parameter AW, default 5: register address width.
REQ-005 SHALL have parameter LD_STAGE, default 1: first stage index at which load data is valid (1 <= LD_STAGE < NSTAGE).
REQ-006 SHALL have parameter CW, default 16: stall counter width; SW = clog2(NSTAGE+1) is derived.
REQ-007 clk  input  1  rising-edge clock; the block has one clock.
REQ-008 rst_n  input  1  reset, asynchronous and active-low.
REQ-009 issue_valid  input  1  instruction presented for issue this cycle.
REQ-010 issue_we  input  1  issued instruction writes a register.
REQ-011 issue_is_load  input  1  issued instruction is a load.
REQ-012 issue_rd  input  AW  destination register of issued instruction.
REQ-013 issue_rs  input  NSRC*AW  source register per channel, channel c at bits [c*AW +: AW].
REQ-014 rf_data  input  NSRC*SIZE  register-file read data per channel.
REQ-015 stage_data  input  NSTAGE*SIZE  result value held by stage k at [k*SIZE +: SIZE].
REQ-016 flush  input  1  kill all in-flight entries.
REQ-017 src_o  output  NSRC*SIZE  forwarded operand per channel.
REQ-018 fwd_sel_o  output  NSRC*SW  per channel: 0 = register file, k+1 = stage k.
REQ-019 stall_o  output  1  issue must be held this cycle (load-use hazard).
REQ-020 stall_cnt_o  output  CW  saturating count of stall cycles.

Function
REQ-021 SHALL keep an NSTAGE-entry shift register; each entry holds {valid, we, is_load, rd}; entry k is the instruction issued k+1 accepted-shift cycles earlier.
REQ-022 Every clock SHALL shift entry k to k+1; entry NSTAGE-1 is discarded.
REQ-023 Entry 0 SHALL load {issue_valid, issue_we, issue_is_load, issue_rd} when stall_o=0, else a bubble (valid=0).
REQ-024 flush=1 SHALL clear valid in all entries at the next edge, overriding REQ-022/023; an issue in the same cycle is dropped.
REQ-025 Stage k SHALL match channel c when valid&we, rd==rs[c], and rs[c]!=0; register 0 never forwards.
REQ-026 Per channel, the lowest matching k (youngest) SHALL win; fwd_sel_o=k+1, src_o=stage_data[k].
REQ-027 With no match, fwd_sel_o=0 and src_o=rf_data for that channel.
REQ-028 If the winning entry has is_load=1 and k<LD_STAGE, stall_o SHALL assert; an older ready match SHALL NOT override it.
REQ-029 stall_o SHALL assert only when issue_valid=1; it is combinational from entries and issue inputs, and flush=1 forces stall_o=0.
REQ-030 src_o/fwd_sel_o SHALL be combinational, zero latency, valid every cycle regardless of issue_valid.
REQ-031 stall_cnt_o SHALL increment by 1 on each edge where stall_o=1 and saturate at 2^CW-1.
REQ-032 Channels SHALL be independent; the same stage may feed several channels simultaneously.

Reset
REQ-033 rst_n=0 SHALL immediately clear all entry valid bits and stall_cnt_o to 0, independent of clk.
REQ-034 During and after reset: stall_o=0, fwd_sel_o=0 on all channels, src_o=rf_data.
REQ-035 Reset asserted mid-stall SHALL drop the stalled state; the first cycle after release behaves as empty pipeline.

Verification
REQ-036 Issue ADD rd=5; next cycle rs0=5, stage_data[0]=0xAAAA5555 -> fwd_sel_o[0]=1, src_o[0]=0xAAAA5555, stall_o=0.
REQ-037 Stage0 and stage2 both write rd=7, rs1=7 -> fwd_sel_o[1]=1 (youngest), src_o[1]=stage_data[0].
REQ-038 LOAD rd=3, next cycle issue rs0=3 (LD_STAGE=1) -> stall_o=1 one cycle, stall_cnt_o 0->1, then fwd_sel_o[0]=2, stall_o=0.
REQ-039 rs0=0 with stage0 writing rd=0 -> fwd_sel_o[0]=0, src_o[0]=rf_data[0].
REQ-040 flush while entries valid -> next cycle all fwd_sel_o=0, stall_o=0; CW=2 with 5 stall cycles -> stall_cnt_o=3.
REQ-041 rst_n low asynchronously mid-stall -> stall_o=0, stall_cnt_o=0 before next clk edge.
